irq_timer_bank: RTL and testbench
=================================

Name: irq_timer_bank

Overview:
Parametrised bank of NUM_CH programmable interval timers. It generates periodic or one-shot interrupt requests for the processor core, and replaces the fixed free-running interrupt counters and the ad-hoc toggle registers in the top level. Each channel has its own period, mode and enable. Pending flags are held until the core acknowledges them. A fixed-priority encoder presents one interrupt line plus the channel index.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
CH_W, 2, width of channel index; must equal ceil(log2(NUM_CH)), min 1
CNT_W, 26, counter/period width in bits (covers 1 s at 25 MHz)

Ports:
clk_25mhz  in   1       system clock
rst        in   1       reset, synchronous, active-high
cfg_we     in   1       configuration write strobe, one cycle
cfg_ch     in   CH_W    channel addressed by cfg_we
cfg_period in   CNT_W   period in clk_25mhz cycles; 0 = channel idle
cfg_oneshot in  1       1 = one-shot, 0 = periodic
cfg_en     in   1       channel enable
ack        in   1       acknowledge strobe, one cycle
ack_ch     in   CH_W    channel whose pending flag is cleared
irq        out  1       OR of all pending flags
irq_ch     out  CH_W    lowest-index pending channel; 0 when irq=0
pending    out  NUM_CH  per-channel pending flags
tick       out  NUM_CH  one-cycle terminal-count pulse per channel

Behaviour:
- Reset: rst is synchronous and active-high on clk_25mhz. All counters, periods, enables, modes, pending, tick and overrun are 0. irq=0, irq_ch=0. Reset overrides cfg_we and ack in the same cycle. Reset mid-count discards all state.
- Per channel, registered state: cnt[CNT_W], period[CNT_W], en, oneshot, pending.
- Config write (cfg_we=1, cfg_ch=k, k<NUM_CH):
  - Next edge: period_k<=cfg_period, oneshot_k<=cfg_oneshot, en_k<=cfg_en, cnt_k<=0, pending_k<=0.
  - cfg_ch>=NUM_CH is ignored.
- Counting: while en_k=1 and period_k!=0:
  - cnt_k increments each cycle.
  - At the edge where cnt_k==period_k-1: cnt_k<=0, tick_k<=1 for exactly one cycle, pending_k<=1.
  - If oneshot_k=1, en_k<=0 on the same edge.
- Latency: first tick is visible P cycles after the config-write edge (P=period). Periodic ticks repeat every P cycles. P=1 gives tick high continuously.
- period_k==0 or en_k==0: cnt_k holds, no tick.
- Ack: ack=1, ack_ch=k gives pending_k<=0 at the next edge. ack_ch>=NUM_CH is ignored.
- Simultaneous events on the same channel, same cycle:
  - cfg write and terminal count: cfg write wins; no tick, pending_k=0.
  - ack and terminal count: set wins; pending_k stays 1, tick_k pulses.
  - cfg write and ack: cfg write wins; pending_k=0.
- Different channels are fully independent; events on separate channels in the same cycle all take effect.
- Counter arithmetic is unsigned, CNT_W bits. The compare is exact equality, so the counter never wraps past period-1.
- irq and irq_ch are combinational from the pending registers (zero added latency). irq_ch priority: index 0 highest.
- tick is registered and deasserts the cycle after its pulse unless another terminal count occurs.

Optional Feature:
Macro IRQ_TIMER_OVERRUN_EN.
- Defined:
  - Adds output port overrun [NUM_CH].
  - overrun_k<=1 when a terminal count occurs while pending_k is already 1 and no ack for k is present that cycle.
  - overrun_k is cleared by ack of k or a cfg write to k; reset 0.
  - Simultaneous ack of k and terminal count on k: overrun_k is not set.
- Not defined: port absent, no overrun logic; all other behaviour identical.

Test Plan:
- Reset, then write ch0 period=5, periodic, en=1 -> tick[0] high 5, 10 and 15 cycles after the write edge; pending[0]=1 from first tick; irq=1, irq_ch=0.
- ch1 period=3 one-shot -> single tick[1] 3 cycles after the write; en cleared; no further ticks for 20 cycles; ack ch1 -> pending[1]=0 next cycle, irq=0.
- ch2 period=4 and ch3 period=4 written the same cycle pair; ack ch2 after tick -> irq_ch=2 while both pending, then irq_ch=3 after the ack; irq stays 1 until ch3 is acked.
- ack ch0 in the same cycle as ch0 terminal count -> pending[0] remains 1; cfg write ch0 on its terminal-count cycle -> no tick, pending[0]=0, count restarts from 0.
- period=0 with en=1 -> no tick for 100 cycles. period=1 -> tick high every cycle. rst asserted mid-count -> all outputs 0 on the next edge and no ticks until reprogrammed.
- With IRQ_TIMER_OVERRUN_EN: ch0 period=2, no ack -> overrun[0]=1 at the second tick; ack ch0 -> overrun[0]=0 and pending[0]=0.

Source files
------------

// File: rtl/irq_timer_bank.sv
// Bank of NUM_CH programmable interval timers with held pending flags and a fixed-priority irq encoder.
// Optional overrun flags per channel when IRQ_TIMER_OVERRUN_EN is defined.
module irq_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 26
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  input  logic              cfg_en,
  input  logic              ack,
  input  logic [CH_W-1:0]   ack_ch,
  output logic              irq,
  output logic [CH_W-1:0]   irq_ch,
`ifdef IRQ_TIMER_OVERRUN_EN
  output logic [NUM_CH-1:0] overrun,
`endif
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic             en_q;
    logic             oneshot_q;
    logic             pend_q;
    logic             tick_q;
    logic             cfg_hit;
    logic             ack_hit;
    logic             tc;

    // Out-of-range channel numbers never match any k, so they are ignored.
    assign cfg_hit = cfg_we && (cfg_ch == CH_W'(k));
    assign ack_hit = ack && (ack_ch == CH_W'(k));
    assign tc      = en_q && (period_q != '0) && (cnt_q == period_q - CNT_W'(1));

    always_ff @(posedge clk_25mhz) begin
      if (rst) begin
        cnt_q     <= '0;
        period_q  <= '0;
        en_q      <= 1'b0;
        oneshot_q <= 1'b0;
        pend_q    <= 1'b0;
        tick_q    <= 1'b0;
      end else if (cfg_hit) begin
        period_q  <= cfg_period;
        oneshot_q <= cfg_oneshot;
        en_q      <= cfg_en;
        cnt_q     <= '0;
        pend_q    <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        tick_q <= tc;
        if (tc) begin
          cnt_q  <= '0;
          pend_q <= 1'b1;
          if (oneshot_q) en_q <= 1'b0;
        end else begin
          if (en_q && (period_q != '0)) cnt_q <= cnt_q + CNT_W'(1);
          if (ack_hit) pend_q <= 1'b0;
        end
      end
    end

`ifdef IRQ_TIMER_OVERRUN_EN
    logic ovr_q;

    // An ack arriving with the terminal count masks the overrun.
    always_ff @(posedge clk_25mhz) begin
      if (rst || cfg_hit || ack_hit) ovr_q <= 1'b0;
      else if (tc && pend_q)         ovr_q <= 1'b1;
    end

    assign overrun[k] = ovr_q;
`endif

    assign pending[k] = pend_q;
    assign tick[k]    = tick_q;
  end

  // Descending scan so the lowest pending index ends up selected.
  always_comb begin
    irq_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) irq_ch = CH_W'(i);
    end
    irq = |pending;
  end

endmodule

// File: tb/tb_irq_timer_bank.sv
// Random-stimulus bench for irq_timer_bank against a time-based reference model.
// Three channels with a 2-bit index so out-of-range channel numbers are exercised.
module tb_irq_timer_bank;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 8;
  localparam int CYCLES = 6000;

  logic              clk_25mhz = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_oneshot;
  logic              cfg_en;
  logic              ack;
  logic [CH_W-1:0]   ack_ch;
  logic              irq;
  logic [CH_W-1:0]   irq_ch;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] tick;
`ifdef IRQ_TIMER_OVERRUN_EN
  logic [NUM_CH-1:0] overrun;
`endif

  always #20 clk_25mhz = ~clk_25mhz;

  irq_timer_bank #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk_25mhz   (clk_25mhz),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .cfg_en      (cfg_en),
    .ack         (ack),
    .ack_ch      (ack_ch),
    .irq         (irq),
    .irq_ch      (irq_ch),
`ifdef IRQ_TIMER_OVERRUN_EN
    .overrun     (overrun),
`endif
    .pending     (pending),
    .tick        (tick)
  );

  // Reference model: a channel started at edge s with period P ticks at every
  // edge n > s where (n - s) is a multiple of P, until stopped.
  int                m_per   [NUM_CH];
  int                m_start [NUM_CH];
  bit                m_one   [NUM_CH];
  bit                m_act   [NUM_CH];
  logic [NUM_CH-1:0] m_pend;
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_ovr;
  int                edge_no;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_no, got, exp);
    end
  endtask

  task automatic model_edge();
    bit tc;
    for (int k = 0; k < NUM_CH; k++) begin
      tc = m_act[k] && (m_per[k] != 0) && (((edge_no - m_start[k]) % m_per[k]) == 0);
      if (rst) begin
        m_per[k] = 0; m_one[k] = 0; m_act[k] = 0; m_start[k] = 0;
        m_pend[k] = 0; m_tick[k] = 0; m_ovr[k] = 0;
      end else if (cfg_we && int'(cfg_ch) == k) begin
        m_per[k]   = int'(cfg_period);
        m_one[k]   = cfg_oneshot;
        m_act[k]   = cfg_en;
        m_start[k] = edge_no;
        m_pend[k]  = 0; m_tick[k] = 0; m_ovr[k] = 0;
      end else begin
        bit acked;
        acked = ack && int'(ack_ch) == k;
        if (acked) m_ovr[k] = 0;
        else if (tc && m_pend[k]) m_ovr[k] = 1;
        m_tick[k] = tc;
        if (tc) m_pend[k] = 1;
        else if (acked) m_pend[k] = 0;
        if (tc && m_one[k]) m_act[k] = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    int exp_ch;
    exp_ch = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) if (m_pend[k]) exp_ch = k;
    check("pending", pending, m_pend);
    check("tick", tick, m_tick);
    check("irq", irq, (m_pend != 0) ? 1 : 0);
    check("irq_ch", irq_ch, exp_ch);
`ifdef IRQ_TIMER_OVERRUN_EN
    check("overrun", overrun, m_ovr);
`endif
  endtask

  initial begin
    int r;
    vectors = 0; miscompares = 0; edge_no = 0;
    m_pend = '0; m_tick = '0; m_ovr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_per[k] = 0; m_start[k] = 0; m_one[k] = 0; m_act[k] = 0;
    end
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    cfg_oneshot = 1'b0; cfg_en = 1'b0; ack = 1'b0; ack_ch = '0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk_25mhz);
      if (cyc > 0) compare_outputs();
      rst         = (cyc < 2) || ($urandom_range(0, 399) == 0);
      cfg_we      = ($urandom_range(0, 11) == 0);
      cfg_ch      = CH_W'($urandom_range(0, 3));
      r           = $urandom_range(0, 15);
      cfg_period  = (r == 15) ? CNT_W'(200) : CNT_W'(r % 8);
      cfg_oneshot = ($urandom_range(0, 2) == 0);
      cfg_en      = ($urandom_range(0, 5) != 0);
      ack         = ($urandom_range(0, 3) == 0);
      ack_ch      = CH_W'($urandom_range(0, 3));
      edge_no++;
      model_edge();
      @(posedge clk_25mhz);
    end
    @(negedge clk_25mhz);
    compare_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
